// File: rtl/fifo_rd_stream.sv
`default_nettype none
// ============================================================================
// Module   : fifo_rd_stream
// Brief    : Read-side consumer for the dual-clock FIFO. Pops the FIFO
//            (1-cycle registered read latency) and presents the words as a
//            valid/ready stream through a 2-entry skid buffer. A flush pulse
//            discards buffered data and drains the FIFO until it is empty.
// Config   : define FIFO_RD_STREAM_CNT_EN to add the 16-bit word_cnt port
//            counting accepted transfers.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_rd_stream #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                rdclk,
  input  logic                rst_n,
  input  logic                fifo_empty,
  input  logic [WIDTH-1:0]    fifo_q,
  input  logic [(DEPTH>>1):0] fifo_rdusedw,
  output logic                fifo_rd,
  output logic [WIDTH-1:0]    out_data,
  output logic                out_valid,
  input  logic                out_ready,
  input  logic                flush,
  output logic                busy,
  output logic                flush_done,
  output logic [(DEPTH>>1):0] fifo_level
`ifdef FIFO_RD_STREAM_CNT_EN
  ,
  output logic [15:0]         word_cnt
`endif
);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [1:0]         r_cnt, w_cnt_nxt;
  logic               r_rd_d1;
  logic               r_active;
  logic [WIDTH-1:0]   r_buf0, r_buf1;
  logic [WIDTH-1:0]   w_buf0_nxt, w_buf1_nxt;
  logic               w_rd;
  logic               w_pop;
  logic [1:0]         w_proj;
  logic [1:0]         w_slot;
  logic [(DEPTH>>1):0] r_fifo_level;

  // Head of the skid buffer drives the stream; nothing from fifo_q reaches it combinationally.
  assign out_valid  = (r_cnt != 2'd0);
  assign out_data   = r_buf0;
  assign w_pop      = out_valid & out_ready;
  assign fifo_level = r_fifo_level;
  // r_active holds off reads until the first clock after reset release, so
  // fifo_rd is low for the whole reset period regardless of fifo_empty.
  assign fifo_rd    = w_rd & r_active;

  // Next-state, read-request and skid-buffer update logic.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_buf0_nxt  = r_buf0;
    w_buf1_nxt  = r_buf1;
    w_rd        = 1'b0;
    busy        = 1'b0;
    flush_done  = 1'b0;
    // Entries already in the buffer plus the word returning from the FIFO this cycle.
    w_proj      = r_cnt + {1'b0, r_rd_d1};
    // Slot the returning word lands in, after any pop has shifted the buffer.
    w_slot      = r_cnt - {1'b0, w_pop};
    if (r_state == ST_RUN) begin
      w_rd = !fifo_empty && ((w_proj < 2'd2) || ((w_proj == 2'd2) && w_pop));
      if (flush) begin
        // Buffered words and the one arriving now are discarded.
        w_state_nxt = ST_DRAIN;
        w_cnt_nxt   = 2'd0;
      end else begin
        if (w_pop) begin
          w_buf0_nxt = r_buf1;
        end
        if (r_rd_d1) begin
          if (w_slot == 2'd0) begin
            w_buf0_nxt = fifo_q;
          end else begin
            w_buf1_nxt = fifo_q;
          end
        end
        w_cnt_nxt = w_slot + {1'b0, r_rd_d1};
      end
    end else begin
      // Discard everything the FIFO returns until it is empty and nothing is in flight.
      busy = 1'b1;
      w_rd = !fifo_empty;
      if (fifo_empty && !r_rd_d1) begin
        flush_done  = 1'b1;
        w_state_nxt = ST_RUN;
      end
    end
  end

  // State, occupancy, read pipeline and buffer registers.
  always_ff @(posedge rdclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_RUN;
      r_cnt    <= 2'd0;
      r_rd_d1  <= 1'b0;
      r_active <= 1'b0;
      r_buf0   <= '0;
      r_buf1   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_rd_d1  <= fifo_rd;
      r_active <= 1'b1;
      r_buf0   <= w_buf0_nxt;
      r_buf1   <= w_buf1_nxt;
    end
  end

  // Registered FIFO fill level, status only.
  always_ff @(posedge rdclk or negedge rst_n) begin
    if (!rst_n) begin
      r_fifo_level <= '0;
    end else begin
      r_fifo_level <= fifo_rdusedw;
    end
  end

`ifdef FIFO_RD_STREAM_CNT_EN
  logic [15:0] r_word_cnt;

  assign word_cnt = r_word_cnt;

  // Accepted-transfer counter; wraps naturally and survives flush.
  always_ff @(posedge rdclk or negedge rst_n) begin
    if (!rst_n) begin
      r_word_cnt <= 16'd0;
    end else if (w_pop) begin
      r_word_cnt <= r_word_cnt + 16'd1;
    end
  end
`endif

endmodule
`default_nettype wire
